// File: rtl/i2c_arb_pkg.sv
// Shared types and widths for the I2C transaction arbiter.
package i2c_arb_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin winner selection: combinational one-hot pick at/after the pointer,
// pointer advances past the winner when the grant is taken.
module rr_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int PW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [NREQ-1:0] req,
  input  logic            grant_en,
  output logic [NREQ-1:0] winner,
  output logic            any_req
);

  logic [PW-1:0]   ptr_reg;
  logic [PW-1:0]   winner_idx;
  logic [NREQ-1:0] mask;
  logic [NREQ-1:0] masked;
  logic [NREQ-1:0] pick_src;

  // Requests at or above the pointer win first; otherwise wrap to the lowest.
  assign mask     = {NREQ{1'b1}} << ptr_reg;
  assign masked   = req & mask;
  assign pick_src = (masked != '0) ? masked : req;
  assign winner   = pick_src & (~pick_src + 1'b1);
  assign any_req  = |req;

  always_comb begin
    winner_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner[i]) winner_idx = PW'(i);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_reg <= '0;
    end else if (grant_en) begin
      ptr_reg <= (winner_idx == PW'(NREQ - 1)) ? '0 : winner_idx + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Shares one I2C master between NREQ requesters: round-robin capture, launch,
// wait for done with timeout, and return status/read data to the owner.
module i2c_txn_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NREQ           = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TW             = 13
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        req_rw,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        rsp_valid,
  output logic                   rsp_err,
  output logic [DATA_W-1:0]      rsp_data,
  output logic                   busy,
  output logic                   m_en,
  output logic                   m_rw,
  output logic [ADDR_W-1:0]      m_addr,
  output logic [DATA_W-1:0]      m_data,
  input  logic                   m_done,
  input  logic [DATA_W-1:0]      m_rdata
);

  localparam logic [TW-1:0] LAST_CNT = TW'(TIMEOUT_CYCLES - 1);

  state_t              state_reg, state_next;
  logic [TW-1:0]       cnt_reg, cnt_next;
  logic [NREQ-1:0]     owner_reg, owner_next;
  logic [NREQ-1:0]     gnt_reg, gnt_next;
  logic                m_en_reg, m_en_next;
  logic                m_rw_reg, m_rw_next;
  logic [ADDR_W-1:0]   m_addr_reg, m_addr_next;
  logic [DATA_W-1:0]   m_data_reg, m_data_next;
  logic                rsp_err_reg, rsp_err_next;
  logic [DATA_W-1:0]   rsp_data_reg, rsp_data_next;

  logic [NREQ-1:0]     winner;
  logic                any_req;
  logic                grant_en;
  logic                timed_out;
  logic                sel_rw;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;
  logic [ADDR_W-1:0]   addr_arr [NREQ];
  logic [DATA_W-1:0]   data_arr [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
      assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .grant_en (grant_en),
    .winner   (winner),
    .any_req  (any_req)
  );

  always_comb begin
    sel_rw   = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner[i]) begin
        sel_rw   = req_rw[i];
        sel_addr = addr_arr[i];
        sel_data = data_arr[i];
      end
    end
  end

  assign timed_out = (cnt_reg == LAST_CNT);

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    owner_next    = owner_reg;
    gnt_next      = '0;
    m_en_next     = m_en_reg;
    m_rw_next     = m_rw_reg;
    m_addr_next   = m_addr_reg;
    m_data_next   = m_data_reg;
    rsp_err_next  = rsp_err_reg;
    rsp_data_next = rsp_data_reg;
    grant_en      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          grant_en    = 1'b1;
          owner_next  = winner;
          gnt_next    = winner;
          m_rw_next   = sel_rw;
          m_addr_next = sel_addr;
          m_data_next = sel_data;
          cnt_next    = '0;
          state_next  = LAUNCH;
        end
      end
      LAUNCH: begin
        // A done still high from the previous transaction must clear first.
        if (!m_done) begin
          m_en_next  = 1'b1;
          cnt_next   = '0;
          state_next = WAIT;
        end else if (timed_out) begin
          rsp_err_next  = 1'b1;
          rsp_data_next = '0;
          state_next    = RESP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      WAIT: begin
        cnt_next = cnt_reg + 1'b1;
        if (m_done) begin
          m_en_next     = 1'b0;
          rsp_err_next  = 1'b0;
          rsp_data_next = m_rw_reg ? m_rdata : '0;
          state_next    = RESP;
        end else if (timed_out) begin
          m_en_next     = 1'b0;
          rsp_err_next  = 1'b1;
          rsp_data_next = '0;
          state_next    = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      owner_reg    <= '0;
      gnt_reg      <= '0;
      m_en_reg     <= 1'b0;
      m_rw_reg     <= 1'b0;
      m_addr_reg   <= '0;
      m_data_reg   <= '0;
      rsp_err_reg  <= 1'b0;
      rsp_data_reg <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      owner_reg    <= owner_next;
      gnt_reg      <= gnt_next;
      m_en_reg     <= m_en_next;
      m_rw_reg     <= m_rw_next;
      m_addr_reg   <= m_addr_next;
      m_data_reg   <= m_data_next;
      rsp_err_reg  <= rsp_err_next;
      rsp_data_reg <= rsp_data_next;
    end
  end

  assign gnt       = gnt_reg;
  assign rsp_valid = (state_reg == RESP) ? owner_reg : '0;
  assign rsp_err   = rsp_err_reg;
  assign rsp_data  = rsp_data_reg;
  assign busy      = (state_reg != IDLE);
  assign m_en      = m_en_reg;
  assign m_rw      = m_rw_reg;
  assign m_addr    = m_addr_reg;
  assign m_data    = m_data_reg;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed bench for i2c_txn_arbiter with a grant/response scoreboard and a
// small controller model that raises done after a programmable delay.
`timescale 1ns/1ps
module tb_i2c_txn_arbiter;

  localparam int N = 4;

  typedef struct packed {
    logic [N-1:0] who;
    logic         err;
    logic [7:0]   data;
  } rsp_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] req_rw = '0;
  logic [N*7-1:0] req_addr = '0;
  logic [N*8-1:0] req_data = '0;
  logic [N-1:0] gnt, rsp_valid;
  logic         rsp_err, busy, m_en, m_rw;
  logic [7:0]   rsp_data, m_data;
  logic [6:0]   m_addr;
  logic         m_done = 1'b0;
  logic [7:0]   m_rdata = 8'h00;

  logic [N-1:0] req_to = '0;
  logic [N-1:0] gnt_to, rsp_valid_to;
  logic         rsp_err_to, busy_to, m_en_to, m_rw_to;
  logic [7:0]   rsp_data_to, m_data_to;
  logic [6:0]   m_addr_to;
  logic         m_done_to = 1'b0;
  logic [7:0]   m_rdata_to = 8'h00;

  int total = 0;
  int bad = 0;
  rsp_t         rsp_q[$];
  logic [N-1:0] gnt_q[$];

  int         done_delay = 5;
  int         stale_hold = 0;
  logic [7:0] rdata_val = 8'h00;
  int         en_cnt = 0;
  int         hold_cnt = 0;

  always #5 clk = ~clk;

  i2c_txn_arbiter #(.NREQ(N), .TIMEOUT_CYCLES(4096), .TW(13)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_rw(req_rw),
    .req_addr(req_addr), .req_data(req_data), .gnt(gnt), .rsp_valid(rsp_valid),
    .rsp_err(rsp_err), .rsp_data(rsp_data), .busy(busy), .m_en(m_en),
    .m_rw(m_rw), .m_addr(m_addr), .m_data(m_data), .m_done(m_done),
    .m_rdata(m_rdata)
  );

  // Short-timeout instance whose controller never answers.
  i2c_txn_arbiter #(.NREQ(N), .TIMEOUT_CYCLES(16), .TW(5)) dut_to (
    .clk(clk), .reset_n(reset_n), .req(req_to), .req_rw(req_rw),
    .req_addr(req_addr), .req_data(req_data), .gnt(gnt_to), .rsp_valid(rsp_valid_to),
    .rsp_err(rsp_err_to), .rsp_data(rsp_data_to), .busy(busy_to), .m_en(m_en_to),
    .m_rw(m_rw_to), .m_addr(m_addr_to), .m_data(m_data_to), .m_done(m_done_to),
    .m_rdata(m_rdata_to)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Controller model: done after done_delay cycles of m_en, held stale_hold cycles after m_en drops.
  always @(posedge clk) begin
    if (m_en) begin
      hold_cnt <= 0;
      en_cnt   <= en_cnt + 1;
      if (en_cnt + 1 == done_delay) begin
        m_done  <= 1'b1;
        m_rdata <= rdata_val;
      end
    end else begin
      en_cnt <= 0;
      if (m_done) begin
        if (hold_cnt >= stale_hold) begin
          m_done  <= 1'b0;
          m_rdata <= 8'h00;
        end else begin
          hold_cnt <= hold_cnt + 1;
        end
      end
    end
  end

  logic [N-1:0] prev_gnt = '0;
  logic         prev_m_en = 1'b0;
  logic         prev_m_done = 1'b0;

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_gnt    <= '0;
      prev_m_en   <= 1'b0;
      prev_m_done <= 1'b0;
    end else begin
      if (gnt != '0) begin
        chk("gnt_one_cycle", 32'(gnt & prev_gnt), 32'h0);
        if (gnt_q.size() == 0) chk("gnt_unexpected", 32'(gnt), 32'h0);
        else begin
          chk("gnt_order", 32'(gnt), 32'(gnt_q[0]));
          void'(gnt_q.pop_front());
        end
      end
      if (rsp_valid != '0) begin
        if (rsp_q.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 32'h0);
        else begin
          chk("rsp_who", 32'(rsp_valid), 32'(rsp_q[0].who));
          chk("rsp_err", 32'(rsp_err), 32'(rsp_q[0].err));
          chk("rsp_data", 32'(rsp_data), 32'(rsp_q[0].data));
          void'(rsp_q.pop_front());
        end
      end
      if (m_en && !prev_m_en) chk("no_stale_done", 32'(prev_m_done), 32'h0);
      prev_gnt    <= gnt;
      prev_m_en   <= m_en;
      prev_m_done <= m_done;
    end
  end

  task automatic wait_gnt(input logic [N-1:0] who);
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if ((gnt & who) != '0) break;
    end
    chk("gnt_wait", 32'(k < 200), 32'h1);
    req = req & ~who;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 500; k++) begin
      @(negedge clk);
      if (!busy && rsp_q.size() == 0 && gnt_q.size() == 0) break;
    end
    chk("idle_wait", 32'(k < 500), 32'h1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int n;
    int hi;

    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_m_en", 32'(m_en), 32'h0);
    chk("rst_m_addr", 32'(m_addr), 32'h0);
    chk("rst_m_data", 32'(m_data), 32'h0);
    chk("rst_rsp_data", 32'(rsp_data), 32'h0);
    reset_n = 1'b1;

    // Single write from requester 1
    done_delay = 20;
    req_addr[13:7] = 7'h12;
    req_data[15:8] = 8'hA5;
    gnt_q.push_back(4'b0010);
    rsp_q.push_back({4'b0010, 1'b0, 8'h00});
    req[1] = 1'b1;
    wait_gnt(4'b0010);
    chk("t1_m_addr", 32'(m_addr), 32'h12);
    chk("t1_m_data", 32'(m_data), 32'hA5);
    chk("t1_m_rw", 32'(m_rw), 32'h0);
    for (k = 0; k < 10 && !m_en; k++) @(negedge clk);
    repeat (5) @(negedge clk);
    chk("t1_m_en_held", 32'(m_en), 32'h1);
    chk("t1_m_addr_stable", 32'(m_addr), 32'h12);
    wait_idle();

    // All four requesters held: rotation 0,1,2,3,0
    do_reset();
    done_delay = 3;
    gnt_q.push_back(4'b0001);
    gnt_q.push_back(4'b0010);
    gnt_q.push_back(4'b0100);
    gnt_q.push_back(4'b1000);
    gnt_q.push_back(4'b0001);
    for (int i = 0; i < 4; i++) rsp_q.push_back({4'(1 << i), 1'b0, 8'h00});
    rsp_q.push_back({4'b0001, 1'b0, 8'h00});
    req = 4'b1111;
    n = 0;
    for (k = 0; k < 400 && n < 5; k++) begin
      @(negedge clk);
      if (gnt != '0) n++;
    end
    req = '0;
    chk("rr_grant_count", 32'(n), 32'd5);
    wait_idle();

    // Read from requester 2
    done_delay = 4;
    rdata_val = 8'h3C;
    req_rw[2] = 1'b1;
    req_addr[20:14] = 7'h05;
    gnt_q.push_back(4'b0100);
    rsp_q.push_back({4'b0100, 1'b0, 8'h3C});
    req[2] = 1'b1;
    wait_gnt(4'b0100);
    chk("t3_m_addr", 32'(m_addr), 32'h05);
    chk("t3_m_rw", 32'(m_rw), 32'h1);
    wait_idle();
    req_rw = '0;

    // Timeout on the 16-cycle instance
    do_reset();
    req_to = 4'b1000;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (gnt_to != '0) break;
    end
    chk("to_gnt", 32'(gnt_to), 32'b1000);
    req_to = '0;
    for (k = 0; k < 50; k++) begin
      if (m_en_to) break;
      @(negedge clk);
    end
    hi = 0;
    for (k = 0; k < 100 && m_en_to; k++) begin
      hi++;
      @(negedge clk);
    end
    chk("to_en_cycles", 32'(hi), 32'd16);
    chk("to_rsp_valid", 32'(rsp_valid_to), 32'b1000);
    chk("to_rsp_err", 32'(rsp_err_to), 32'h1);
    chk("to_rsp_data", 32'(rsp_data_to), 32'h0);
    req_to = 4'b0100;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (gnt_to != '0) break;
    end
    chk("to_next_gnt", 32'(gnt_to), 32'b0100);
    req_to = '0;

    // Back-to-back reads from requester 0 with a stale done between them
    done_delay = 4;
    stale_hold = 10;
    rdata_val = 8'h11;
    req_rw[0] = 1'b1;
    gnt_q.push_back(4'b0001);
    gnt_q.push_back(4'b0001);
    rsp_q.push_back({4'b0001, 1'b0, 8'h11});
    rsp_q.push_back({4'b0001, 1'b0, 8'h22});
    req[0] = 1'b1;
    for (k = 0; k < 200 && rsp_q.size() > 1; k++) @(negedge clk);
    rdata_val = 8'h22;
    for (k = 0; k < 200 && gnt_q.size() > 0; k++) @(negedge clk);
    req[0] = 1'b0;
    chk("stale_done_seen", 32'(m_done), 32'h1);
    chk("stale_m_en_low", 32'(m_en), 32'h0);
    wait_idle();
    stale_hold = 0;
    req_rw = '0;

    // Asynchronous reset during WAIT
    done_delay = 50;
    gnt_q.push_back(4'b0100);
    req[2] = 1'b1;
    wait_gnt(4'b0100);
    for (k = 0; k < 10 && !m_en; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("rst_mid_m_en_before", 32'(m_en), 32'h1);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_m_en", 32'(m_en), 32'h0);
    chk("rst_mid_busy", 32'(busy), 32'h0);
    chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'h0);
    req = 4'b1111;
    done_delay = 2;
    repeat (2) @(negedge clk);
    gnt_q.push_back(4'b0001);
    rsp_q.push_back({4'b0001, 1'b0, 8'h00});
    reset_n = 1'b1;
    wait_gnt(4'b0001);
    req = '0;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
